// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM encoding, register map and STATUS bit layout.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    localparam logic [31:0] REG_DATA     = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS   = 32'h0000_0004;
    localparam int unsigned ADDR_SEL_BIT = 2;

    localparam int unsigned STAT_NOT_EMPTY = 0;
    localparam int unsigned STAT_OVR       = 1;
    localparam int unsigned STAT_FERR      = 2;
    localparam int unsigned STAT_PERR      = 3;
    localparam int unsigned STAT_COUNT_LSB = 8;

    // Assemble the STATUS register word; unlisted bits read as zero.
    function automatic logic [31:0] status_word(input logic [7:0] count,
                                                input logic       perr,
                                                input logic       ferr,
                                                input logic       ovr,
                                                input logic       not_empty);
        logic [31:0] w;
        w                       = '0;
        w[STAT_NOT_EMPTY]       = not_empty;
        w[STAT_OVR]             = ovr;
        w[STAT_FERR]            = ferr;
        w[STAT_PERR]            = perr;
        w[STAT_COUNT_LSB +: 8]  = count;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// picorv32-style memory bus slice seen by the UART receiver (select line plus request/response).
interface uart_rx_if;
    logic        enable;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output enable, mem_valid, mem_instr, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  enable, mem_valid, mem_instr, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with first-word fall-through head and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot a same-cycle push needs, so push at full succeeds alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end
endmodule

// File: rtl/uart_rx.sv
// Bus-attached 8N1 UART receiver with RX FIFO and DATA/STATUS registers.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic     clk,
    input  logic     resetn,
    uart_rx_if.slave bus,
    input  logic     serialIn
);
    localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;
    localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
    localparam int unsigned FCNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(BAUD_DIV - 1);

    logic              sync1, rx;
    rx_state_t         state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [2:0]        bitcnt, bitcnt_n;
    logic [7:0]        shreg, shreg_n;
    logic              frame_perr, frame_perr_n;
    logic              expired_c;
    logic              push_c, ferr_set_c, perr_set_c;
    logic              ovr, ferr, perr;
    logic [7:0]        fifo_dout;
    logic              fifo_full, fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    logic              req_c, is_wr_c, sel_status_c, sel_data_c, pop_c, ovr_set_c;
    logic [3:0]        clr_c;
    logic [31:0]       status_c;
    logic              unused_c;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            rx    <= 1'b1;
        end else begin
            sync1 <= serialIn;
            rx    <= sync1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            frame_perr <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bitcnt     <= bitcnt_n;
            shreg      <= shreg_n;
            frame_perr <= frame_perr_n;
        end
    end

    assign expired_c = (cnt == '0);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        bitcnt_n     = bitcnt;
        shreg_n      = shreg;
        frame_perr_n = frame_perr;
        push_c       = 1'b0;
        ferr_set_c   = 1'b0;
        perr_set_c   = 1'b0;
        if (!expired_c) cnt_n = cnt - CNT_W'(1);
        case (state)
            // IDLE is only ever entered with rx high, so a low level marks the falling edge.
            ST_IDLE: begin
                if (!rx) begin
                    cnt_n        = HALF_RELOAD;
                    bitcnt_n     = '0;
                    frame_perr_n = 1'b0;
                    state_n      = ST_START;
                end
            end
            ST_START: begin
                if (expired_c) begin
                    if (rx) begin
                        state_n = ST_IDLE;
                    end else begin
                        cnt_n   = FULL_RELOAD;
                        state_n = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (expired_c) begin
                    shreg_n[bitcnt] = rx;
                    cnt_n           = FULL_RELOAD;
                    bitcnt_n        = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (expired_c) begin
                    if ((^shreg) != rx) begin
                        perr_set_c   = 1'b1;
                        frame_perr_n = 1'b1;
                    end
                    cnt_n   = FULL_RELOAD;
                    state_n = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (expired_c) begin
                    if (rx) begin
                        push_c  = !frame_perr;
                        state_n = ST_IDLE;
                    end else begin
                        ferr_set_c = 1'b1;
                        state_n    = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rx) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .push  (push_c),
        .pop   (pop_c),
        .din   (shreg),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Bus decode; the pop lands on the same edge that registers mem_ready and the head byte.
    assign req_c        = bus.enable && bus.mem_valid && !bus.mem_ready;
    assign is_wr_c      = |bus.mem_wstrb;
    assign sel_status_c = (bus.mem_addr[ADDR_SEL_BIT] == REG_STATUS[ADDR_SEL_BIT]);
    assign sel_data_c   = (bus.mem_addr[ADDR_SEL_BIT] == REG_DATA[ADDR_SEL_BIT]);
    assign pop_c        = req_c && !is_wr_c && sel_data_c;
    assign clr_c        = (req_c && is_wr_c && sel_status_c) ? bus.mem_wdata[3:0] : 4'b0;
    assign ovr_set_c    = push_c && fifo_full && !pop_c;
    assign status_c     = status_word(8'(fifo_count), perr, ferr, ovr, !fifo_empty);

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovr  <= (ovr  & ~clr_c[STAT_OVR])  | ovr_set_c;
            ferr <= (ferr & ~clr_c[STAT_FERR]) | ferr_set_c;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) perr <= 1'b0;
        else         perr <= (perr & ~clr_c[STAT_PERR]) | perr_set_c;
    end
`else
    assign perr = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            bus.mem_ready <= req_c;
            bus.mem_rdata <= '0;
            if (req_c && !is_wr_c) begin
                if (sel_status_c)     bus.mem_rdata <= status_c;
                else if (!fifo_empty) bus.mem_rdata <= {24'h0, fifo_dout};
            end
        end
    end

    assign unused_c = &{1'b0, bus.mem_instr, bus.mem_addr[31:3], bus.mem_addr[1:0],
                        bus.mem_wdata[31:4], clr_c[STAT_NOT_EMPTY], clr_c[STAT_PERR], perr_set_c};
endmodule
